// File: rtl/bk_adder_arbiter.sv
// Two-requester round-robin front end around one Brent-Kung prefix adder, with multi-beat carry chaining.
// Latency: 1 cycle from accepted beat to registered response; one beat per cycle.
// Backpressure: a request is taken only while the result register is empty or draining; a chain owner blocks the other port.
module bk_adder_arbiter #(
    parameter int WIDTH   = 16,
    parameter int VALENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req0_last,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    input  logic             req1_last,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id,
    output logic             rsp_last
);

    // Prefix network spans the carry-in slot plus WIDTH operand bits.
    localparam int N   = WIDTH + 1;
    localparam int LOG = $clog2(N);

    // The prefix cells below are radix-2; other valencies or non power-of-two widths are rejected at elaboration.
    if (VALENCY != 2) begin : g_bad_valency
        $error("bk_adder_arbiter: only VALENCY=2 prefix cells are implemented");
    end
    if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
        $error("bk_adder_arbiter: WIDTH must be a power of two and at least 4");
    end

    typedef enum logic {IDLE, LOCK} state_t;

    state_t           state_q;
    logic             rr_q;        // requester favoured when both are valid
    logic             owner_q;     // chain owner while in LOCK
    logic             carry_q;     // carry handed from one chain beat to the next
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_sum_q;
    logic             rsp_cout_q;
    logic             rsp_id_q;
    logic             rsp_last_q;

    logic             can_accept;
    logic             gnt_vld;
    logic             gnt_id;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic             op_last;
    logic [N-1:0]     g_pre;
    logic [N-1:0]     p_pre;
    logic [N-1:0]     gg;
    logic [N-1:0]     pp;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    assign can_accept = !rsp_valid_q || rsp_ready;

    // Grant selection: chain owner in LOCK, otherwise the sole valid requester or the round-robin favourite.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (state_q == LOCK) begin
            gnt_id  = owner_q;
            gnt_vld = owner_q ? req1_valid : req0_valid;
        end else if (req0_valid && req1_valid) begin
            gnt_id  = rr_q;
            gnt_vld = 1'b1;
        end else if (req1_valid) begin
            gnt_id  = 1'b1;
            gnt_vld = 1'b1;
        end else if (req0_valid) begin
            gnt_id  = 1'b0;
            gnt_vld = 1'b1;
        end
    end

    // Ready is held low while reset is asserted even though the state is already forced to IDLE.
    assign accept     = gnt_vld && can_accept && rst_n;
    assign req0_ready = accept && !gnt_id;
    assign req1_ready = accept && gnt_id;

    // Operand mux; inside a chain the stored carry replaces the requester's carry-in.
    always_comb begin
        op_a    = gnt_id ? req1_a    : req0_a;
        op_b    = gnt_id ? req1_b    : req0_b;
        op_last = gnt_id ? req1_last : req0_last;
        op_cin  = (state_q == LOCK) ? carry_q : (gnt_id ? req1_cin : req0_cin);
    end

    // Bitwise generate/propagate with the carry-in folded in as bit 0.
    always_comb begin
        g_pre    = '0;
        p_pre    = '0;
        g_pre[0] = op_cin;
        p_pre[0] = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            g_pre[i+1] = op_a[i] & op_b[i];
            p_pre[i+1] = op_a[i] ^ op_b[i];
        end
    end

    // Brent-Kung group PG: up-sweep builds power-of-two prefixes, down-sweep fills the remaining positions.
    always_comb begin
        gg = g_pre;
        pp = p_pre;
        for (int d = 1; d < N; d = d * 2) begin
            for (int i = 2 * d - 1; i < N; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        for (int d = (1 << (LOG - 1)); d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < N; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
            end
        end
    end

    // Sum post-logic: each bit's propagate XOR the group carry into it.
    assign sum_d  = p_pre[WIDTH:1] ^ gg[WIDTH-1:0];
    assign cout_d = gg[WIDTH];

    // Arbitration FSM, chain carry and the response register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            owner_q     <= 1'b0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            if (accept) begin
                rsp_valid_q <= 1'b1;
                rsp_sum_q   <= sum_d;
                rsp_cout_q  <= cout_d;
                rsp_id_q    <= gnt_id;
                rsp_last_q  <= op_last;
            end else if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end

            if (accept) begin
                case (state_q)
                    IDLE: begin
                        if (op_last) begin
                            rr_q <= !gnt_id;
                        end else begin
                            state_q <= LOCK;
                            owner_q <= gnt_id;
                            carry_q <= cout_d;
                        end
                    end
                    LOCK: begin
                        if (op_last) begin
                            state_q <= IDLE;
                            rr_q    <= !owner_q;
                            carry_q <= 1'b0;
                        end else begin
                            carry_q <= cout_d;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_last  = rsp_last_q;

endmodule
